// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_arbiter_rr : N-master bus arbiter, fixed-priority or round-robin,    |
// |                  registered grants with optional per-tenure hold limit.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module bus_arbiter_rr #(
   parameter int  NUM_REQ  = 2,
   parameter int  RR_MODE  = 0,
   parameter int  MAX_HOLD = 0,
   localparam int IDW      = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] bus_bid,
   output logic [NUM_REQ-1:0] bus_grant,
   output logic [IDW-1:0]     grant_id,
   output logic               bus_busy,
   output logic               hold_expired
);

   localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
   logic               expired_q, expired_d;
   logic               mask_q, mask_d;

   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] other_bid;
   logic [NUM_REQ-1:0] eligible_bid;
   logic               win_found;
   logic [IDW-1:0]     win_idx;

   // k-th candidate in the search order: descending from last-1 (RR) or from the top (fixed)
   function automatic logic [IDW-1:0] search_idx(input logic [IDW-1:0] last, input int k);
      int raw;
      if (RR_MODE != 0) begin
         raw = (int'(last) + 2 * NUM_REQ - 1 - k) % NUM_REQ;
      end else begin
         raw = NUM_REQ - 1 - k;
      end
      return IDW'(raw);
   endfunction

   assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
   assign other_bid = bus_bid & ~owner_oh;

   always_comb begin
      eligible_bid = bus_bid;
      // an owner cut off by the hold limit steps aside once if anyone else is waiting
      if (mask_q && (|other_bid)) begin
         eligible_bid = other_bid;
      end
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && eligible_bid[search_idx(last_q, k)]) begin
            win_found = 1'b1;
            win_idx   = search_idx(last_q, k);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      mask_d     = mask_q;
      expired_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d    = ST_GRANT;
               owner_d    = win_idx;
               last_d     = win_idx;
               hold_cnt_d = '0;
               mask_d     = 1'b0;
            end
         end
         ST_GRANT: begin
            if (!bus_bid[owner_q]) begin
               state_d = ST_IDLE;
            end else if ((MAX_HOLD > 0) && (hold_cnt_q == HCW'(MAX_HOLD - 1))) begin
               state_d   = ST_IDLE;
               expired_d = 1'b1;
               mask_d    = 1'b1;
            end else if (hold_cnt_q != {HCW{1'b1}}) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         last_q     <= '0;
         hold_cnt_q <= '0;
         expired_q  <= 1'b0;
         mask_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         expired_q  <= expired_d;
         mask_q     <= mask_d;
      end
   end

   assign bus_busy     = (state_q == ST_GRANT);
   assign bus_grant    = bus_busy ? owner_oh : '0;
   assign grant_id     = bus_busy ? owner_q : '0;
   assign hold_expired = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus_arbiter_rr : four arbiter configurations against a tenure model.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_bus_arbiter_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] bids [4];

   logic [1:0] bid0, g0, bid2, g2;
   logic [3:0] bid1, g1, bid3, g3;
   logic       id0, id2;
   logic [1:0] id1, id3;
   logic       busy0, busy1, busy2, busy3;
   logic       ex0, ex1, ex2, ex3;

   assign bid0 = bids[0][1:0];
   assign bid1 = bids[1];
   assign bid2 = bids[2][1:0];
   assign bid3 = bids[3];

   bus_arbiter_rr #(.NUM_REQ(2), .RR_MODE(0), .MAX_HOLD(0)) u0 (
      .clk(clk), .reset(rst), .bus_bid(bid0), .bus_grant(g0), .grant_id(id0),
      .bus_busy(busy0), .hold_expired(ex0));
   bus_arbiter_rr #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(0)) u1 (
      .clk(clk), .reset(rst), .bus_bid(bid1), .bus_grant(g1), .grant_id(id1),
      .bus_busy(busy1), .hold_expired(ex1));
   bus_arbiter_rr #(.NUM_REQ(2), .RR_MODE(0), .MAX_HOLD(3)) u2 (
      .clk(clk), .reset(rst), .bus_bid(bid2), .bus_grant(g2), .grant_id(id2),
      .bus_busy(busy2), .hold_expired(ex2));
   bus_arbiter_rr #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(3)) u3 (
      .clk(clk), .reset(rst), .bus_bid(bid3), .bus_grant(g3), .grant_id(id3),
      .bus_busy(busy3), .hold_expired(ex3));

   // Tenure-level view of the bus: who owns it, for how many cycles so far,
   // and which master (if any) must step aside after being cut off.
   typedef struct {
      bit busy;
      int owner;
      int last;
      int held;
      bit exp;
      int masked;
   } mdl_t;

   int   cfg_n  [4] = '{2, 4, 2, 4};
   int   cfg_rr [4] = '{0, 1, 0, 1};
   int   cfg_mh [4] = '{0, 0, 3, 3};
   mdl_t m [4];
   int   errs   = 0;
   int   checks = 0;

   function automatic mdl_t step(mdl_t s, logic [3:0] b_in, logic r, int n, int rr, int mh);
      mdl_t       t;
      logic [3:0] b;
      int         start;
      int         w;
      t     = s;
      t.exp = 0;
      if (r) begin
         t.busy = 0; t.owner = 0; t.last = 0; t.held = 0; t.masked = -1;
         return t;
      end
      b = b_in & 4'((1 << n) - 1);
      if (!s.busy) begin
         if (s.masked >= 0 && (b & ~(4'b0001 << s.masked)) != 4'b0000)
            b = b & ~(4'b0001 << s.masked);
         start = (rr != 0) ? (s.last + n - 1) % n : n - 1;
         w = -1;
         for (int k = 0; k < n; k++)
            if (w < 0 && b[(start - k + n) % n] == 1'b1) w = (start - k + n) % n;
         if (w >= 0) begin
            t.busy = 1; t.owner = w; t.last = w; t.held = 1; t.masked = -1;
         end
      end else if (b[s.owner] == 1'b0) begin
         t.busy = 0;
      end else if (mh > 0 && s.held >= mh) begin
         t.busy = 0; t.exp = 1; t.masked = s.owner;
      end else begin
         t.held = s.held + 1;
      end
      return t;
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] og, oi, ob, ox;
      for (int d = 0; d < 4; d++) begin
         case (d)
            0:       begin og = 32'(g0); oi = 32'(id0); ob = 32'(busy0); ox = 32'(ex0); end
            1:       begin og = 32'(g1); oi = 32'(id1); ob = 32'(busy1); ox = 32'(ex1); end
            2:       begin og = 32'(g2); oi = 32'(id2); ob = 32'(busy2); ox = 32'(ex2); end
            default: begin og = 32'(g3); oi = 32'(id3); ob = 32'(busy3); ox = 32'(ex3); end
         endcase
         chk({tag, "_grant"}, d, og, m[d].busy ? (32'd1 << m[d].owner) : 32'd0);
         chk({tag, "_id"},    d, oi, m[d].busy ? 32'(m[d].owner) : 32'd0);
         chk({tag, "_busy"},  d, ob, 32'(m[d].busy));
         chk({tag, "_hexp"},  d, ox, 32'(m[d].exp));
      end
   endtask

   // Inputs are set at the falling edge; the model advances with the rising edge.
   task automatic tick(input string tag);
      mdl_t nx [4];
      for (int d = 0; d < 4; d++)
         nx[d] = step(m[d], bids[d], rst, cfg_n[d], cfg_rr[d], cfg_mh[d]);
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 4; d++) m[d] = nx[d];
      check_all(tag);
   endtask

   task automatic clear_bids();
      for (int d = 0; d < 4; d++) bids[d] = 4'b0000;
   endtask

   initial begin
      int order [$];
      int rr_exp [5] = '{3, 2, 1, 0, 3};
      int t4_g [5]   = '{2, 2, 2, 0, 1};
      int t4_x [5]   = '{0, 0, 0, 1, 0};
      int t5_g [9]   = '{4, 4, 4, 0, 4, 4, 4, 0, 4};
      int t5_x [9]   = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
      bit prev_busy;

      for (int d = 0; d < 4; d++) begin
         m[d].busy = 0; m[d].owner = 0; m[d].last = 0;
         m[d].held = 0; m[d].exp = 0; m[d].masked = -1;
      end

      // reset with every master bidding
      rst = 1'b1;
      for (int d = 0; d < 4; d++) bids[d] = 4'b1111;
      tick("rst1");
      tick("rst2");
      rst = 1'b0;
      tick("rst_rel");

      // fixed priority, two masters
      rst = 1'b1; clear_bids(); tick("t2_rst"); rst = 1'b0;
      bids[0] = 4'b0011;
      tick("t2_a");
      chk("t2_first_grant", 0, 32'(g0), 32'h2);
      tick("t2_b"); tick("t2_c"); tick("t2_d");
      bids[0] = 4'b0001;
      tick("t2_e");
      chk("t2_turnaround", 0, 32'(busy0), 32'h0);
      tick("t2_f");
      chk("t2_second_grant", 0, 32'(g0), 32'h1);

      // round-robin order with 2-cycle tenures
      rst = 1'b1; clear_bids(); tick("t3_rst"); rst = 1'b0;
      prev_busy = 0;
      for (int i = 0; i < 15; i++) begin
         bids[1] = 4'b1111;
         if (m[1].busy && m[1].held == 2) bids[1][m[1].owner] = 1'b0;
         tick("t3");
         if (busy1 && !prev_busy) order.push_back(int'(id1));
         prev_busy = busy1;
      end
      for (int i = 0; i < 5; i++)
         chk("t3_rr_order", 1, (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));

      // hold limit hands the bus to the waiting master
      rst = 1'b1; clear_bids(); tick("t4_rst"); rst = 1'b0;
      bids[2] = 4'b0011;
      tick("t4_arb");
      for (int i = 0; i < 5; i++) begin
         chk("t4_grant", 2, 32'(g2), 32'(t4_g[i]));
         chk("t4_hexp", 2, 32'(ex2), 32'(t4_x[i]));
         tick("t4");
      end

      // sole bidder is re-granted after each expiry
      rst = 1'b1; clear_bids(); tick("t5_rst"); rst = 1'b0;
      bids[3] = 4'b0100;
      tick("t5_arb");
      for (int i = 0; i < 9; i++) begin
         chk("t5_grant", 3, 32'(g3), 32'(t5_g[i]));
         chk("t5_hexp", 3, 32'(ex3), 32'(t5_x[i]));
         tick("t5");
      end

      // reset in the middle of a tenure
      rst = 1'b1; clear_bids(); tick("t6_rst"); rst = 1'b0;
      bids[1] = 4'b0010;
      tick("t6_a");
      chk("t6_owner", 1, 32'(id1), 32'h1);
      tick("t6_b");
      rst = 1'b1;
      tick("t6_rst_mid");
      chk("t6_dropped", 1, 32'(g1), 32'h0);
      rst = 1'b0;
      bids[1] = 4'b1111;
      tick("t6_c");
      chk("t6_first_after_rst", 1, 32'(id1), 32'h3);

      // randomised traffic with occasional resets
      clear_bids();
      for (int i = 0; i < 2000; i++) begin
         for (int d = 0; d < 4; d++)
            for (int b = 0; b < cfg_n[d]; b++)
               if ($urandom_range(3) == 0) bids[d][b] = ~bids[d][b];
         rst = ($urandom_range(199) == 0);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire
